// File: rtl/alu_mc.sv
// alu_mc: multi-cycle integer execute unit (RV base ops in 1 cycle, RV-M mul/div iterative radix-2).
// Rev 1.0
`default_nettype none
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5,
    parameter bit EN_M  = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       in_op_i,
    input  logic             in_alt_i,
    input  logic [WIDTH-1:0] in_a_i,
    input  logic [WIDTH-1:0] in_b_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_res_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic             out_dz_o
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

    state_t             state_q;
    logic [2:0]         op_q;
    logic               neg_q, bz_q, valid_q, dz_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   opnd_q, hi_q, lo_q, res_q;
    logic [TAG_W-1:0]   tag_q;

    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = valid_q;
    assign out_res_o   = res_q;
    assign out_tag_o   = tag_q;
    assign out_dz_o    = dz_q;

    // Single-cycle base ops
    logic [CNT_W-1:0]        shamt;
    logic signed [WIDTH-1:0] sra_res;
    logic [WIDTH-1:0]        base_res_d;
    assign shamt   = in_b_i[CNT_W-1:0];
    assign sra_res = $signed(in_a_i) >>> shamt;

    always_comb begin
        base_res_d = '0;
        case (in_op_i[2:0])
            3'b000: base_res_d = in_alt_i ? (in_a_i - in_b_i) : (in_a_i + in_b_i);
            3'b001: base_res_d = in_a_i << shamt;
            3'b010: base_res_d = {{(WIDTH-1){1'b0}}, ($signed(in_a_i) < $signed(in_b_i))};
            3'b011: base_res_d = {{(WIDTH-1){1'b0}}, (in_a_i < in_b_i)};
            3'b100: base_res_d = in_a_i ^ in_b_i;
            3'b101: base_res_d = in_alt_i ? $unsigned(sra_res) : (in_a_i >> shamt);
            3'b110: base_res_d = in_a_i | in_b_i;
            default: base_res_d = in_a_i & in_b_i;
        endcase
    end

    // Operand magnitudes and final sign for the M group
    logic             is_div, a_sgn, b_sgn, sa, sb, neg_d;
    logic [WIDTH-1:0] mag_a, mag_b;
    always_comb begin
        is_div = in_op_i[2];
        a_sgn  = is_div ? ~in_op_i[0] : (in_op_i[1:0] == 2'b01 || in_op_i[1:0] == 2'b10);
        b_sgn  = is_div ? ~in_op_i[0] : (in_op_i[1:0] == 2'b01);
        sa     = a_sgn & in_a_i[WIDTH-1];
        sb     = b_sgn & in_b_i[WIDTH-1];
        mag_a  = sa ? (-in_a_i) : in_a_i;
        mag_b  = sb ? (-in_b_i) : in_b_i;
        neg_d  = (is_div && in_op_i[1]) ? sa : (sa ^ sb);
    end

    // hi/lo hold {product high, multiplier} for mul and {remainder, dividend/quotient} for div
    logic [WIDTH:0]       mul_sum, div_rs;
    logic [WIDTH+1:0]     div_diff;
    logic                 div_ge;
    logic [WIDTH-1:0]     hi_d, lo_d, m_res_d;
    logic [2*WIDTH-1:0]   prod, prod_s;
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        div_rs   = {hi_q, lo_q[WIDTH-1]};
        div_diff = {1'b0, div_rs} - {2'b00, opnd_q};
        div_ge   = ~div_diff[WIDTH+1];
        if (op_q[2]) begin
            hi_d = div_ge ? div_diff[WIDTH-1:0] : div_rs[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], div_ge};
        end else begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        prod   = {hi_d, lo_d};
        prod_s = neg_q ? (-prod) : prod;
        case (op_q)
            3'b000:         m_res_d = prod_s[WIDTH-1:0];
            3'b001, 3'b010,
            3'b011:         m_res_d = prod_s[2*WIDTH-1:WIDTH];
            3'b100, 3'b101: m_res_d = bz_q ? {WIDTH{1'b1}} : (neg_q ? (-lo_d) : lo_d);
            default:        m_res_d = neg_q ? (-hi_d) : hi_d;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            neg_q   <= 1'b0;
            bz_q    <= 1'b0;
            cnt_q   <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            valid_q <= 1'b0;
            res_q   <= '0;
            tag_q   <= '0;
            dz_q    <= 1'b0;
        end else if (flush_i) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid_i) begin
                    tag_q <= in_tag_i;
                    if (!in_op_i[3] || !EN_M) begin
                        res_q   <= in_op_i[3] ? '0 : base_res_d;
                        dz_q    <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        op_q    <= in_op_i[2:0];
                        neg_q   <= neg_d;
                        bz_q    <= is_div & (in_b_i == '0);
                        opnd_q  <= is_div ? mag_b : mag_a;
                        hi_q    <= '0;
                        lo_q    <= is_div ? mag_a : mag_b;
                        cnt_q   <= '0;
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == C_LAST) begin
                        res_q   <= m_res_d;
                        dz_q    <= bz_q;
                        valid_q <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: if (out_ready_i) begin
                    valid_q <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc (WIDTH=32).
// Rev 1.0
`default_nettype none
module tb_alu_mc;
    localparam int W  = 32;
    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          flush_i = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_alt_i = 1'b0;
    logic          out_ready_i = 1'b1;
    logic [3:0]    in_op_i = '0;
    logic [W-1:0]  in_a_i = '0;
    logic [W-1:0]  in_b_i = '0;
    logic [TW-1:0] in_tag_i = '0;
    logic          in_ready_o, out_valid_o, out_dz_o;
    logic [W-1:0]  out_res_o;
    logic [TW-1:0] out_tag_o;

    int n_tests = 0;
    int n_fail  = 0;

    alu_mc #(.WIDTH(W), .TAG_W(TW), .EN_M(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_op_i(in_op_i),
        .in_alt_i(in_alt_i), .in_a_i(in_a_i), .in_b_i(in_b_i), .in_tag_i(in_tag_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_res_o(out_res_o),
        .out_tag_o(out_tag_o), .out_dz_o(out_dz_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called #1 after an edge; returns #1 after the accept edge.
    task automatic issue(input string nm, input logic [3:0] op, input logic alt,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] tg);
        chk({nm, "_rdy"}, 64'(in_ready_o), 64'd1);
        in_op_i = op; in_alt_i = alt; in_a_i = a; in_b_i = b; in_tag_i = tg;
        in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid_o && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run(input string nm, input logic [3:0] op, input logic alt,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] tg,
                       input logic [W-1:0] er, input logic ed, input int el);
        int lat;
        issue(nm, op, alt, a, b, tg);
        wait_valid(lat);
        chk({nm, "_lat"}, 64'(lat), 64'(el));
        chk({nm, "_res"}, 64'(out_res_o), 64'(er));
        chk({nm, "_dz"},  64'(out_dz_o), 64'(ed));
        chk({nm, "_tag"}, 64'(out_tag_o), 64'(tg));
        @(posedge clk); #1;
    endtask

    initial begin
        int  lat;
        bit  seen;
        logic [W-1:0] held;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid_o), 64'd0);
        chk("rst_res",   64'(out_res_o),   64'd0);
        chk("rst_tag",   64'(out_tag_o),   64'd0);
        chk("rst_dz",    64'(out_dz_o),    64'd0);
        chk("rst_rdy",   64'(in_ready_o),  64'd1);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Base ops
        run("sub",  4'h0, 1'b1, 32'd5,        32'd7,        5'd3,  32'hFFFF_FFFE, 1'b0, 1);
        run("add",  4'h0, 1'b0, 32'hFFFF_FFFF, 32'd2,       5'd4,  32'h0000_0001, 1'b0, 1);
        run("sra",  4'h5, 1'b1, 32'h8000_0000, 32'h24,      5'd5,  32'hF800_0000, 1'b0, 1);
        run("srl",  4'h5, 1'b0, 32'h8000_0000, 32'h24,      5'd6,  32'h0800_0000, 1'b0, 1);
        run("sll",  4'h1, 1'b0, 32'd3,         32'h21,      5'd7,  32'd6,         1'b0, 1);
        run("slt",  4'h2, 1'b0, 32'hFFFF_FFFF, 32'd1,       5'd8,  32'd1,         1'b0, 1);
        run("sltu", 4'h3, 1'b0, 32'hFFFF_FFFF, 32'd1,       5'd9,  32'd0,         1'b0, 1);
        run("xor",  4'h4, 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd10, 32'hFF00_0FF0, 1'b0, 1);
        run("or",   4'h6, 1'b0, 32'hF000_0001, 32'h0000_0F00, 5'd11, 32'hF000_0F01, 1'b0, 1);
        run("and",  4'h7, 1'b0, 32'hF0F0_FFFF, 32'h3C3C_00F0, 5'd12, 32'h3030_00F0, 1'b0, 1);

        // Multiply
        run("mulh",   4'h9, 1'b0, 32'h8000_0000, 32'h8000_0000, 5'd13, 32'h4000_0000, 1'b0, 33);
        run("mulhsu", 4'hA, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, 32'hFFFF_FFFF, 1'b0, 33);
        run("mul",    4'h8, 1'b0, 32'd7,         32'hFFFF_FFFD, 5'd15, 32'hFFFF_FFEB, 1'b0, 33);
        run("mulhu",  4'hB, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd16, 32'hFFFF_FFFE, 1'b0, 33);
        run("mulh2",  4'h9, 1'b0, 32'hFFFF_FFF9, 32'd3,         5'd17, 32'hFFFF_FFFF, 1'b0, 33);

        // Divide
        run("div",    4'hC, 1'b0, 32'hFFFF_FFF9, 32'd2,         5'd18, 32'hFFFF_FFFD, 1'b0, 33);
        run("rem",    4'hE, 1'b0, 32'hFFFF_FFF9, 32'd2,         5'd19, 32'hFFFF_FFFF, 1'b0, 33);
        run("divu0",  4'hD, 1'b0, 32'd9,         32'd0,         5'd20, 32'hFFFF_FFFF, 1'b1, 33);
        run("divov",  4'hC, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 32'h8000_0000, 1'b0, 33);
        run("remov",  4'hE, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 32'd0,         1'b0, 33);
        run("rem0",   4'hE, 1'b0, 32'hFFFF_FFFB, 32'd0,         5'd23, 32'hFFFF_FFFB, 1'b1, 33);
        run("div0",   4'hC, 1'b0, 32'hFFFF_FFFB, 32'd0,         5'd24, 32'hFFFF_FFFF, 1'b1, 33);
        run("remu",   4'hF, 1'b0, 32'd100,       32'd7,         5'd25, 32'd2,         1'b0, 33);
        run("divu",   4'hD, 1'b0, 32'hFFFF_FFF0, 32'd16,        5'd26, 32'h0FFF_FFFF, 1'b0, 33);

        // Backpressure
        out_ready_i = 1'b0;
        issue("bp", 4'h0, 1'b0, 32'd40, 32'd2, 5'd27);
        wait_valid(lat);
        held = out_res_o;
        chk("bp_first", 64'(held), 64'd42);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", 64'(out_valid_o), 64'd1);
            chk("bp_res",   64'(out_res_o),   64'd42);
            chk("bp_tag",   64'(out_tag_o),   64'd27);
            chk("bp_rdy",   64'(in_ready_o),  64'd0);
        end
        out_ready_i = 1'b1;
        @(posedge clk); #1;
        chk("bp_rel_valid", 64'(out_valid_o), 64'd0);
        chk("bp_rel_rdy",   64'(in_ready_o),  64'd1);
        run("bp_next", 4'h4, 1'b0, 32'hFF, 32'h0F, 5'd28, 32'hF0, 1'b0, 1);

        // Flush in BUSY cycle 10
        issue("fl", 4'hC, 1'b0, 32'd1000, 32'd3, 5'd29);
        repeat (9) @(posedge clk);
        #1 flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        chk("fl_valid", 64'(out_valid_o), 64'd0);
        chk("fl_rdy",   64'(in_ready_o),  64'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid_o) seen = 1'b1;
        end
        chk("fl_no_valid", 64'(seen), 64'd0);
        run("fl_next", 4'hD, 1'b0, 32'd1000, 32'd3, 5'd30, 32'd333, 1'b0, 33);

        // Async reset mid-divide
        issue("ar", 4'hD, 1'b0, 32'd100, 32'd7, 5'd9);
        repeat (5) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("ar_valid", 64'(out_valid_o), 64'd0);
        chk("ar_res",   64'(out_res_o),   64'd0);
        chk("ar_tag",   64'(out_tag_o),   64'd0);
        chk("ar_dz",    64'(out_dz_o),    64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        run("ar_next", 4'hF, 1'b0, 32'd100, 32'd7, 5'd31, 32'd2, 1'b0, 33);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
